// File: rtl/turn_signal_ctrl_pkg.sv
// Shared types and helpers for the turn-signal producer.
package turn_signal_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEFT   = 2'd1,
    RIGHT  = 2'd2,
    HAZARD = 2'd3
  } modetype;

  // Last step of the downstream 4-step light sequence.
  localparam logic [1:0] PHASE_LAST = 2'd3;

  // Conditioned input lanes.
  localparam int NUM_IN    = 3;
  localparam int IDX_LEFT  = 0;
  localparam int IDX_RIGHT = 1;
  localparam int IDX_HAZ   = 2;

  // Hazard dominates; both levers at once is not a valid lever position.
  function automatic modetype decode_req(input logic [NUM_IN-1:0] db);
    modetype m;
    m = IDLE;
    if (db[IDX_HAZ])                        m = HAZARD;
    else if (db[IDX_LEFT] && !db[IDX_RIGHT]) m = LEFT;
    else if (db[IDX_RIGHT] && !db[IDX_LEFT]) m = RIGHT;
    return m;
  endfunction

  function automatic logic drives_left(input modetype m);
    return (m == LEFT) || (m == HAZARD);
  endfunction

  function automatic logic drives_right(input modetype m);
    return (m == RIGHT) || (m == HAZARD);
  endfunction

endpackage

// File: rtl/turn_signal_ctrl_if.sv
// Producer-to-sequencer bundle: blink strobe, per-side levels, mode and phase.
interface turn_signal_if;
  import turn_signal_pkg::*;

  logic       tick;
  logic       turnSignalLeft;
  logic       turnSignalRight;
  modetype    mode;
  logic [1:0] phase;

  modport master (output tick, turnSignalLeft, turnSignalRight, mode, phase);
  modport slave  (input  tick, turnSignalLeft, turnSignalRight, mode, phase);
endinterface

// File: rtl/turn_signal_ctrl_input_debounce.sv
// 2-flop synchronizer followed by a consecutive-sample debounce filter.
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted value; any
  // agreeing sample restarts the run.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer and filter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/turn_signal_ctrl.sv
// Turn-signal producer: conditions lever/hazard inputs, generates the blink
// strobe and mirrors the sequencer phase so a sweep is never cut short.
module turn_signal_ctrl
  import turn_signal_pkg::*;
#(
  parameter int TICK_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          leftReq,
  input  logic          rightReq,
  input  logic          hazardReq,
  turn_signal_if.master sig
);
  localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] db;

  assign raw[IDX_LEFT]  = leftReq;
  assign raw[IDX_RIGHT] = rightReq;
  assign raw[IDX_HAZ]   = hazardReq;

  // One conditioning lane per raw input.
  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[g]),
      .db    (db[g])
    );
  end

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  modetype       mode_q, mode_d, req;
  logic [1:0]    phase_q, phase_d;
  logic          tsl_q, tsl_d;
  logic          tsr_q, tsr_d;
  logic          ts_on;

  assign tick  = (pre_q == PRE_LAST);
  assign req   = decode_req(db);
  assign ts_on = tsl_q | tsr_q;

  // Free-running prescaler, wraps on the tick cycle.
  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // Phase mirror and mode commit; new requests are only taken at the 3->0
  // wrap (or while dark) so the sequencers always finish a full sweep.
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    tsl_d   = tsl_q;
    tsr_d   = tsr_q;
    if (tick) begin
      if (ts_on) phase_d = (phase_q == PHASE_LAST) ? 2'd0 : phase_q + 2'd1;
      else       phase_d = 2'd0;
      if (phase_d == 2'd0) mode_d = req;
      tsl_d = drives_left(mode_d);
      tsr_d = drives_right(mode_d);
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q   <= '0;
      mode_q  <= IDLE;
      phase_q <= 2'd0;
      tsl_q   <= 1'b0;
      tsr_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      tsl_q   <= tsl_d;
      tsr_q   <= tsr_d;
    end
  end

  assign sig.tick            = tick;
  assign sig.turnSignalLeft  = tsl_q;
  assign sig.turnSignalRight = tsr_q;
  assign sig.mode            = mode_q;
  assign sig.phase           = phase_q;

endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Randomized bench for turn_signal_ctrl against a sweep-level reference model.
module tb_turn_signal_ctrl;
  localparam int TD = 4;
  localparam int DC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic l_in = 1'b0, r_in = 1'b0, h_in = 1'b0;

  turn_signal_if tsif ();

  turn_signal_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .leftReq   (l_in),
    .rightReq  (r_in),
    .hazardReq (h_in),
    .sig       (tsif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: history of raw samples, accepted input levels, the
  // active light mode and how many ticks into the current sweep it is.
  bit hist[3][8];
  bit db[3];
  int m_mode, m_k, m_c;

  function automatic int req_mode();
    if (db[2]) return 3;
    if (db[0] && !db[1]) return 1;
    if (db[1] && !db[0]) return 2;
    return 0;
  endfunction

  task automatic model_edge();
    bit rawv[3];
    bit all_diff;
    rawv[0] = l_in; rawv[1] = r_in; rawv[2] = h_in;
    if (reset) begin
      m_c = 0; m_mode = 0; m_k = 0;
      for (int i = 0; i < 3; i++) begin
        db[i] = 0;
        for (int j = 0; j < 8; j++) hist[i][j] = 0;
      end
      return;
    end
    if (m_c % TD == TD - 1) begin
      if (m_mode != 0 && m_k < 3) m_k++;
      else begin
        m_mode = req_mode();
        m_k = 0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      // Synchronized samples seen at this edge lag the raw pin by two edges.
      all_diff = 1;
      for (int j = 1; j <= DC; j++) if (hist[i][j] == db[i]) all_diff = 0;
      if (all_diff) db[i] = !db[i];
      for (int j = 7; j >= 1; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = rawv[i];
    end
    m_c++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("tick",  32'(tsif.tick), 32'((m_c % TD) == TD - 1));
    chk("tsl",   32'(tsif.turnSignalLeft),  32'(m_mode == 1 || m_mode == 3));
    chk("tsr",   32'(tsif.turnSignalRight), 32'(m_mode == 2 || m_mode == 3));
    chk("mode",  32'(tsif.mode), 32'(m_mode));
    chk("phase", 32'(tsif.phase), 32'(m_k));
    chk("overlap", 32'(tsif.turnSignalLeft & tsif.turnSignalRight), 32'(m_mode == 3));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_for(input int mode, input int k, input int lim, input string tag);
    int n;
    n = 0;
    while (!(m_mode == mode && m_k == k) && n < lim) begin
      cyc();
      n++;
    end
    chk(tag, 32'(m_mode == mode && m_k == k), 32'd1);
  endtask

  initial begin
    m_c = 0; m_mode = 0; m_k = 0;
    reset = 1'b1;
    run(3);
    chk("rst_tsl",   32'(tsif.turnSignalLeft), 32'd0);
    chk("rst_tsr",   32'(tsif.turnSignalRight), 32'd0);
    chk("rst_mode",  32'(tsif.mode), 32'd0);
    chk("rst_phase", 32'(tsif.phase), 32'd0);
    chk("rst_tick",  32'(tsif.tick), 32'd0);
    reset = 1'b0;
    run(20);

    // Left lever held, then released at phase 1.
    l_in = 1'b1;
    run(40);
    wait_for(1, 1, 40, "wait_left_ph1");
    l_in = 1'b0;
    run(30);

    // Left to right switch at phase 2.
    l_in = 1'b1;
    wait_for(1, 2, 60, "wait_left_ph2");
    l_in = 1'b0; r_in = 1'b1;
    run(30);

    // Hazard with a lever active, then both levers without hazard.
    h_in = 1'b1;
    run(30);
    h_in = 1'b0; l_in = 1'b1; r_in = 1'b1;
    run(30);
    chk("both_levers_idle", 32'(tsif.mode), 32'd0);

    // Short glitch on the right lever.
    l_in = 1'b0; r_in = 1'b0;
    run(20);
    r_in = 1'b1;
    run(2);
    r_in = 1'b0;
    run(20);
    chk("glitch_idle", 32'(tsif.turnSignalRight), 32'd0);

    // Reset mid-sweep.
    l_in = 1'b1;
    wait_for(1, 2, 60, "wait_rst_ph2");
    reset = 1'b1;
    run(1);
    chk("midrst_tsl",   32'(tsif.turnSignalLeft), 32'd0);
    chk("midrst_mode",  32'(tsif.mode), 32'd0);
    chk("midrst_phase", 32'(tsif.phase), 32'd0);
    reset = 1'b0;
    run(10);

    // Random segments, including glitches and occasional resets.
    for (int s = 0; s < 300; s++) begin
      l_in = 1'($urandom_range(0, 1));
      r_in = 1'($urandom_range(0, 1));
      h_in = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 49) == 0);
      run(1);
      reset = 1'b0;
      run($urandom_range(1, 14));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/turn_signal_ctrl.md
Name: turn_signal_ctrl

Overview:
- Producer side of the turn-signal interface. Conditions the driver's lever and hazard switch inputs and generates a blink-rate strobe.
- Drives per-side turnSignal levels to the left and right blinkers sequencer instances. Those instances advance one light step per tick.
- Mirrors the 4-step sequencer phase, so a started sweep always completes with all three lights before the signal drops or switches sides.

Parameters:
- TICK_DIV, 4, clk cycles per blink step; tick period; must be >= 2.
- DEBOUNCE_CYCLES, 3, consecutive stable synchronized samples needed to accept an input change; >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- leftReq  input  1  raw left lever contact; asynchronous.
- rightReq  input  1  raw right lever contact; asynchronous.
- hazardReq  input  1  raw hazard switch; asynchronous.
- tick  output  1  one-clk strobe every TICK_DIV cycles; clock enable for the downstream sequencers.
- turnSignalLeft  output  1  level to the left sequencer; changes only on tick edges.
- turnSignalRight  output  1  level to the right sequencer; changes only on tick edges.
- mode  output  2  current mode: IDLE=0, LEFT=1, RIGHT=2, HAZARD=3.
- phase  output  2  mirrored sequencer step, 0..3.

Behaviour:
- Reset (synchronous, active-high): all outputs are 0. Synchronizers, debounce counters, the prescaler, mode (IDLE) and phase (0) are all cleared. Reset overrides every other event in the same cycle.
- Input conditioning, per raw input:
  - 2-flop synchronizer.
  - Debounced value updates only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from it.
  - Any sample that agrees with the current debounced value restarts the count.
- Requested mode, decoded from the debounced inputs:
  - hazard=1 -> HAZARD.
  - else left&!right -> LEFT.
  - else right&!left -> RIGHT.
  - else IDLE. Both levers asserted is an illegal lever state and decodes to IDLE.
- Prescaler:
  - Free-running counter 0..TICK_DIV-1.
  - tick=1 exactly in the cycle where count==TICK_DIV-1.
  - First tick is in cycle TICK_DIV-1 after reset deasserts.
- State updates occur only on clk edges where tick=1. mode, phase and both turnSignal registers hold between ticks.
- Phase mirror (ts = the turnSignal value currently driven for the active side(s)):
  - ts=0 -> phase_next=0.
  - ts=1 -> phase_next=(phase+1) mod 4, so 3 wraps to 0.
- Mode commit:
  - mode_next = requested mode only when phase_next==0, i.e. current ts=0 or phase==3.
  - Otherwise mode_next=mode, so an in-progress sweep finishes.
- Outputs, registered and applied on the same tick edge:
  - turnSignalLeft = mode_next in {LEFT, HAZARD}.
  - turnSignalRight = mode_next in {RIGHT, HAZARD}.
  - mode and phase show the registered values.
- Resulting sweep: turnSignal stays high for whole multiples of 4 ticks. Release, side switch and hazard entry/exit all take effect at the 3->0 wrap.
  - Example: LEFT->RIGHT never overlaps. Left drops and right rises at the same tick edge.
- HAZARD starts both sides in the same cycle at phase 0, so the two sequencers stay lockstepped.
- Request latency: 2 sync cycles + DEBOUNCE_CYCLES, then up to TICK_DIV cycles (from IDLE) or up to 4 ticks (mid-sweep).
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes the requested mode.

Decomposition:
- Package turn_signal_pkg:
  - modetype enum {IDLE, LEFT, RIGHT, HAZARD} (logic [1:0]).
  - PHASE_LAST=2'd3.
  - Request-decode function.
- One sub-module: input_debounce (synchronizer + debounce counter; parameter DEBOUNCE_CYCLES), instantiated 3 times.
- Prescaler, phase mirror and mode FSM stay in turn_signal_ctrl.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3):
- Reset, then idle 20 cycles -> tick pulses in cycles 3, 7, 11…; turnSignalLeft/Right=0; mode=0; phase=0.
- leftReq held high -> turnSignalLeft rises at the first tick ≥5 cycles after the input edge. phase then steps 0,1,2,3,0… per tick; turnSignalRight stays 0.
- leftReq released at phase 1 -> turnSignalLeft stays 1 through phase 3, falls at the wrap tick, and mode returns to 0.
- leftReq dropped and rightReq raised mid-sweep (phase 2) -> at the wrap tick, turnSignalLeft 1->0 and turnSignalRight 0->1 in the same cycle; no cycle has both high.
- hazardReq with leftReq active -> after the current sweep, both signals are 1 and phase is shared. Both levers asserted without hazard -> mode=0 after the wrap.
- 2-cycle pulse on rightReq -> no change. Reset asserted mid-sweep at phase 2 -> next cycle all outputs 0 and the prescaler restarts.
